transform_pipeline_sequencer: RTL and testbench

- Frame-level controller that sequences the transform pipeline (vertex shader → vertex post-processor → g-buffer → primitive assembler) across multiple models per frame.
- For each model it performs these steps in order:
  - fetch the model descriptor;
  - load the 4x4 MVP matrix from matrix memory;
  - stream the model's vertices into the pipeline under the pipeline's vertex-ready handshake;
  - supply the triangle count and wait for the pipeline's finished flag;
  - pulse the pipeline reset before moving to the next model.

---
 rtl/transform_pipeline_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_transform_pipeline_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transform_pipeline_sequencer.sv
// Frame-level sequencer for the transform pipeline. For each model of a frame it
// fetches the descriptor, loads the 4x4 MVP matrix, streams the vertices under the
// pipeline's ready handshake, waits for the pipeline to finish, then pulses the
// pipeline reset before moving on to the next model.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | pipeline held in reset, waiting for i_start
// DESC_RD    | descriptor read strobe for model m
// DESC_LATCH | capture base/count/triangles, skip empty models
// MVP_RD     | 16 back-to-back matrix reads plus one capture cycle
// MVP_SEND   | one-cycle o_mvp_dv pulse
// VTX_FETCH  | vertex read strobe at base+i
// VTX_LATCH  | capture vertex data into o_vertex
// VTX_SEND   | hold vertex until i_vertex_ready, then hand it over
// WAIT_FIN   | wait for the pipeline's finished flag
// PIPE_RST   | one-cycle pipeline reset, then next model
// DONE       | frame done pulse, back to IDLE
module transform_pipeline_sequencer #(
    parameter int DATAWIDTH          = 24,
    parameter int MAX_MODELS         = 16,
    parameter int MAX_VERTEX_COUNT   = 16384,
    parameter int MAX_TRIANGLE_COUNT = 16384
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_start,
    input  logic [$clog2(MAX_MODELS):0]                 i_num_models,
    output logic                                        o_busy,
    output logic                                        o_frame_done,
    output logic [$clog2(MAX_MODELS)-1:0]               o_desc_addr,
    output logic                                        o_desc_read_en,
    input  logic [$clog2(MAX_VERTEX_COUNT)-1:0]         i_desc_vertex_base,
    input  logic [$clog2(MAX_VERTEX_COUNT):0]           i_desc_vertex_count,
    input  logic [$clog2(MAX_TRIANGLE_COUNT)-1:0]       i_desc_num_triangles,
    output logic [$clog2(MAX_MODELS)+3:0]               o_mvp_addr,
    output logic                                        o_mvp_read_en,
    input  logic [DATAWIDTH-1:0]                        i_mvp_data,
    output logic [$clog2(MAX_VERTEX_COUNT)-1:0]         o_vtx_addr,
    output logic                                        o_vtx_read_en,
    input  logic [3*DATAWIDTH-1:0]                      i_vtx_data,
    output logic                                        o_pipe_rstn,
    output logic [3:0][3:0][DATAWIDTH-1:0]              o_mvp_matrix,
    output logic                                        o_mvp_dv,
    output logic [2:0][DATAWIDTH-1:0]                   o_vertex,
    output logic                                        o_vertex_dv,
    output logic                                        o_vertex_last,
    input  logic                                        i_vertex_ready,
    output logic [$clog2(MAX_TRIANGLE_COUNT)-1:0]       o_num_triangles,
    input  logic                                        i_pipe_finished
);

    localparam int MW = $clog2(MAX_MODELS);
    localparam int VW = $clog2(MAX_VERTEX_COUNT);
    localparam logic [MW:0] M_ONE  = 1;
    localparam logic [VW:0] VI_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_DESC_RD, S_DESC_LATCH, S_MVP_RD, S_MVP_SEND,
        S_VTX_FETCH, S_VTX_LATCH, S_VTX_SEND, S_WAIT_FIN, S_PIPE_RST, S_DONE
    } state_t;

    state_t          r_state;
    logic [MW:0]     r_num_models;
    logic [MW:0]     r_m;
    logic [VW-1:0]   r_base;
    logic [VW:0]     r_count;
    logic [VW:0]     r_vi;
    logic [4:0]      r_k;

    logic [MW:0]     w_m_next;
    logic            w_last_model;
    logic [3:0]      w_cap_idx;
    logic [VW:0]     w_vi_next;
    logic            w_vi_last;

    assign w_m_next     = r_m + M_ONE;
    assign w_last_model = (w_m_next == r_num_models);
    // r_k counts MVP_RD cycles; data arriving in cycle k belongs to the read of cycle k-1
    assign w_cap_idx    = r_k[3:0] - 4'd1;
    assign w_vi_next    = r_vi + VI_ONE;
    assign w_vi_last    = (w_vi_next == r_count);

    // Handover must follow ready in the same cycle, so valid/last are decoded from state
    assign o_vertex_dv   = (r_state == S_VTX_SEND) && i_vertex_ready;
    assign o_vertex_last = o_vertex_dv && w_vi_last;

    // Sequencer FSM with registered outputs; strobes default low every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_num_models    <= '0;
            r_m             <= '0;
            r_base          <= '0;
            r_count         <= '0;
            r_vi            <= '0;
            r_k             <= '0;
            o_busy          <= 1'b0;
            o_frame_done    <= 1'b0;
            o_desc_addr     <= '0;
            o_desc_read_en  <= 1'b0;
            o_mvp_addr      <= '0;
            o_mvp_read_en   <= 1'b0;
            o_vtx_addr      <= '0;
            o_vtx_read_en   <= 1'b0;
            o_pipe_rstn     <= 1'b0;
            o_mvp_matrix    <= '0;
            o_mvp_dv        <= 1'b0;
            o_vertex        <= '0;
            o_num_triangles <= '0;
        end else begin
            o_frame_done   <= 1'b0;
            o_desc_read_en <= 1'b0;
            o_mvp_read_en  <= 1'b0;
            o_vtx_read_en  <= 1'b0;
            o_mvp_dv       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_pipe_rstn <= 1'b0;
                    o_busy      <= 1'b0;
                    if (i_start) begin
                        r_num_models <= i_num_models;
                        r_m          <= '0;
                        o_busy       <= 1'b1;
                        if (i_num_models == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state        <= S_DESC_RD;
                            o_pipe_rstn    <= 1'b1;
                            o_desc_read_en <= 1'b1;
                            o_desc_addr    <= '0;
                        end
                    end
                end
                S_DESC_RD: r_state <= S_DESC_LATCH;
                S_DESC_LATCH: begin
                    r_base          <= i_desc_vertex_base;
                    r_count         <= i_desc_vertex_count;
                    o_num_triangles <= i_desc_num_triangles;
                    if (i_desc_vertex_count == '0 || i_desc_num_triangles == '0) begin
                        r_m <= w_m_next;
                        if (w_last_model) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state        <= S_DESC_RD;
                            o_desc_read_en <= 1'b1;
                            o_desc_addr    <= w_m_next[MW-1:0];
                        end
                    end else begin
                        r_state       <= S_MVP_RD;
                        r_k           <= '0;
                        o_mvp_read_en <= 1'b1;
                        o_mvp_addr    <= {r_m[MW-1:0], 4'd0};
                    end
                end
                S_MVP_RD: begin
                    if (r_k != 5'd0)
                        o_mvp_matrix[w_cap_idx[3:2]][w_cap_idx[1:0]] <= i_mvp_data;
                    if (r_k == 5'd16) begin
                        r_state  <= S_MVP_SEND;
                        o_mvp_dv <= 1'b1;
                    end else begin
                        r_k <= r_k + 5'd1;
                        if (r_k != 5'd15) begin
                            o_mvp_read_en <= 1'b1;
                            o_mvp_addr    <= {r_m[MW-1:0], r_k[3:0] + 4'd1};
                        end
                    end
                end
                S_MVP_SEND: begin
                    r_state       <= S_VTX_FETCH;
                    r_vi          <= '0;
                    o_vtx_read_en <= 1'b1;
                    o_vtx_addr    <= r_base;
                end
                S_VTX_FETCH: r_state <= S_VTX_LATCH;
                S_VTX_LATCH: begin
                    o_vertex[0] <= i_vtx_data[3*DATAWIDTH-1:2*DATAWIDTH];
                    o_vertex[1] <= i_vtx_data[2*DATAWIDTH-1:DATAWIDTH];
                    o_vertex[2] <= i_vtx_data[DATAWIDTH-1:0];
                    r_state     <= S_VTX_SEND;
                end
                S_VTX_SEND: begin
                    if (i_vertex_ready) begin
                        if (w_vi_last) begin
                            r_state <= S_WAIT_FIN;
                        end else begin
                            r_vi          <= w_vi_next;
                            r_state       <= S_VTX_FETCH;
                            o_vtx_read_en <= 1'b1;
                            o_vtx_addr    <= r_base + w_vi_next[VW-1:0];
                        end
                    end
                end
                S_WAIT_FIN: begin
                    if (i_pipe_finished) begin
                        r_state     <= S_PIPE_RST;
                        o_pipe_rstn <= 1'b0;
                    end
                end
                S_PIPE_RST: begin
                    o_pipe_rstn <= 1'b1;
                    r_m         <= w_m_next;
                    if (w_last_model) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state        <= S_DESC_RD;
                        o_desc_read_en <= 1'b1;
                        o_desc_addr    <= w_m_next[MW-1:0];
                    end
                end
                S_DONE: begin
                    o_frame_done <= 1'b1;
                    o_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_transform_pipeline_sequencer.sv
// Directed bench for transform_pipeline_sequencer: behavioural descriptor, matrix and
// vertex memories with one-cycle latency, a finished-flag responder, and a negedge
// monitor that logs reads and handovers for the directed checks in the main sequence.
module tb_transform_pipeline_sequencer;

    localparam int DW = 24;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_start;
    logic [4:0]           i_num_models;
    logic                 o_busy;
    logic                 o_frame_done;
    logic [3:0]           o_desc_addr;
    logic                 o_desc_read_en;
    logic [13:0]          i_desc_vertex_base;
    logic [14:0]          i_desc_vertex_count;
    logic [13:0]          i_desc_num_triangles;
    logic [7:0]           o_mvp_addr;
    logic                 o_mvp_read_en;
    logic [DW-1:0]        i_mvp_data;
    logic [13:0]          o_vtx_addr;
    logic                 o_vtx_read_en;
    logic [3*DW-1:0]      i_vtx_data;
    logic                 o_pipe_rstn;
    logic [3:0][3:0][DW-1:0] o_mvp_matrix;
    logic                 o_mvp_dv;
    logic [2:0][DW-1:0]   o_vertex;
    logic                 o_vertex_dv;
    logic                 o_vertex_last;
    logic                 i_vertex_ready;
    logic [13:0]          o_num_triangles;
    logic                 i_pipe_finished;

    transform_pipeline_sequencer dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_models(i_num_models),
        .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_desc_addr(o_desc_addr), .o_desc_read_en(o_desc_read_en),
        .i_desc_vertex_base(i_desc_vertex_base), .i_desc_vertex_count(i_desc_vertex_count),
        .i_desc_num_triangles(i_desc_num_triangles),
        .o_mvp_addr(o_mvp_addr), .o_mvp_read_en(o_mvp_read_en), .i_mvp_data(i_mvp_data),
        .o_vtx_addr(o_vtx_addr), .o_vtx_read_en(o_vtx_read_en), .i_vtx_data(i_vtx_data),
        .o_pipe_rstn(o_pipe_rstn), .o_mvp_matrix(o_mvp_matrix), .o_mvp_dv(o_mvp_dv),
        .o_vertex(o_vertex), .o_vertex_dv(o_vertex_dv), .o_vertex_last(o_vertex_last),
        .i_vertex_ready(i_vertex_ready), .o_num_triangles(o_num_triangles),
        .i_pipe_finished(i_pipe_finished)
    );

    always #5 clk = ~clk;

    // memory contents are simple functions of the address
    function automatic logic [DW-1:0] mvp_val(input int a);
        return DW'(a * 37 + 5);
    endfunction
    function automatic logic [DW-1:0] vx(input int a); return DW'(a * 3 + 1); endfunction
    function automatic logic [DW-1:0] vy(input int a); return DW'(a * 3 + 2); endfunction
    function automatic logic [DW-1:0] vz(input int a); return DW'(a * 3 + 3); endfunction
    function automatic logic [2:0][DW-1:0] exp_vert(input int a);
        logic [2:0][DW-1:0] t;
        t[0] = vx(a); t[1] = vy(a); t[2] = vz(a);
        return t;
    endfunction
    function automatic logic [3:0][3:0][DW-1:0] exp_matrix(input int m);
        logic [3:0][3:0][DW-1:0] t;
        for (int k = 0; k < 16; k++) t[k/4][k%4] = mvp_val(m * 16 + k);
        return t;
    endfunction

    int d_base [16];
    int d_count[16];
    int d_tris [16];

    // one-cycle-latency memories
    always @(posedge clk) begin
        if (o_desc_read_en) begin
            i_desc_vertex_base   <= 14'(d_base[o_desc_addr]);
            i_desc_vertex_count  <= 15'(d_count[o_desc_addr]);
            i_desc_num_triangles <= 14'(d_tris[o_desc_addr]);
        end
        if (o_mvp_read_en) i_mvp_data <= mvp_val(int'(o_mvp_addr));
        if (o_vtx_read_en) i_vtx_data <= {vx(int'(o_vtx_addr)), vy(int'(o_vtx_addr)), vz(int'(o_vtx_addr))};
    end

    logic [7:0]      mvp_q[$];
    logic [13:0]     vtx_q[$];
    logic [3*DW-1:0] vert_q[$];
    logic            last_q[$];
    logic [3:0][3:0][DW-1:0] mat_snap;
    int desc_cnt = 0, mvp_dv_cnt = 0, done_cnt = 0, prst_cnt = 0, viol = 0;

    always @(negedge clk) begin
        if (o_mvp_read_en) mvp_q.push_back(o_mvp_addr);
        if (o_vtx_read_en) vtx_q.push_back(o_vtx_addr);
        if (o_desc_read_en) desc_cnt++;
        if (o_mvp_dv) begin mvp_dv_cnt++; mat_snap = o_mvp_matrix; end
        if (o_vertex_dv) begin vert_q.push_back(o_vertex); last_q.push_back(o_vertex_last); end
        if (o_frame_done) done_cnt++;
        if (o_busy && !o_pipe_rstn) prst_cnt++;
        if (o_vertex_dv && !i_vertex_ready) viol++;
        if (int'(o_desc_read_en) + int'(o_mvp_read_en) + int'(o_vtx_read_en) > 1) viol++;
    end

    // pipeline model: raises finished a few cycles after the last vertex
    logic fin_enable = 1'b1;
    initial begin
        i_pipe_finished = 1'b0;
        forever begin
            @(negedge clk);
            if (o_vertex_dv && o_vertex_last && fin_enable) begin
                repeat (3) @(posedge clk);
                #1 i_pipe_finished = 1'b1;
                @(posedge clk);
                #1 i_pipe_finished = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int n);
        @(posedge clk);
        #1 i_start = 1'b1;
        i_num_models = 5'(n);
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_frame(input int d0, input int budget);
        for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
    endtask

    int ms, vs, vq, mdv, pr, dr, d0, bp_dv, bp_chg, ok;
    logic [2:0][DW-1:0] snap;

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_num_models = '0;
        i_vertex_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin d_base[i] = 0; d_count[i] = 0; d_tris[i] = 0; end

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_pipe_rstn", o_pipe_rstn, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_read_strobes", {o_desc_read_en, o_mvp_read_en, o_vtx_read_en}, 0);
        check("rst_dv", {o_mvp_dv, o_vertex_dv, o_vertex_last}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_pipe_rstn", o_pipe_rstn, 0);

        // single model
        d_base[0] = 100; d_count[0] = 3; d_tris[0] = 1;
        ms = mvp_q.size(); vs = vtx_q.size(); vq = vert_q.size();
        mdv = mvp_dv_cnt; pr = prst_cnt; d0 = done_cnt;
        start_frame(1);
        wait_frame(d0, 500);
        check("t1_frame_done", done_cnt - d0, 1);
        check("t1_mvp_reads", mvp_q.size() - ms, 16);
        ok = 1;
        for (int k = 0; k < 16; k++) if (mvp_q[ms + k] != 8'(k)) ok = 0;
        check("t1_mvp_addr_seq", ok, 1);
        check("t1_mvp_dv", mvp_dv_cnt - mdv, 1);
        check("t1_matrix", mat_snap == exp_matrix(0), 1);
        check("t1_vtx_reads", vtx_q.size() - vs, 3);
        check("t1_vaddr0", vtx_q[vs], 100);
        check("t1_vaddr1", vtx_q[vs + 1], 101);
        check("t1_vaddr2", vtx_q[vs + 2], 102);
        check("t1_vert_cnt", vert_q.size() - vq, 3);
        check("t1_vert0", vert_q[vq], exp_vert(100));
        check("t1_vert2", vert_q[vq + 2], exp_vert(102));
        check("t1_last", {last_q[vq], last_q[vq + 1], last_q[vq + 2]}, 3'b001);
        check("t1_tris", o_num_triangles, 1);
        check("t1_pipe_rst_pulses", prst_cnt - pr, 1);
        check("t1_busy_after", o_busy, 0);

        // backpressure
        d_base[0] = 200; d_count[0] = 2; d_tris[0] = 5;
        vq = vert_q.size(); d0 = done_cnt;
        i_vertex_ready = 1'b0;
        start_frame(1);
        for (int c = 0; c < 200 && !o_vtx_read_en; c++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        snap = o_vertex;
        bp_dv = 0; bp_chg = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (o_vertex_dv) bp_dv++;
            if (o_vertex !== snap) bp_chg++;
        end
        check("t2_no_dv_while_low", bp_dv, 0);
        check("t2_vertex_stable", bp_chg, 0);
        check("t2_held_vertex", snap, exp_vert(200));
        @(posedge clk);
        #1 i_vertex_ready = 1'b1;
        @(negedge clk);
        check("t2_dv_first_ready", o_vertex_dv, 1);
        check("t2_vertex_at_dv", o_vertex, exp_vert(200));
        wait_frame(d0, 500);
        check("t2_frame_done", done_cnt - d0, 1);
        check("t2_vert_cnt", vert_q.size() - vq, 2);
        check("t2_vert1", vert_q[vq + 1], exp_vert(201));
        check("t2_last", {last_q[vq], last_q[vq + 1]}, 2'b01);
        check("t2_tris", o_num_triangles, 5);

        // multi-model with a skipped model
        d_base[0] = 10; d_count[0] = 2; d_tris[0] = 1;
        d_base[1] = 20; d_count[1] = 0; d_tris[1] = 4;
        d_base[2] = 30; d_count[2] = 1; d_tris[2] = 2;
        ms = mvp_q.size(); vs = vtx_q.size(); vq = vert_q.size();
        mdv = mvp_dv_cnt; pr = prst_cnt; dr = desc_cnt; d0 = done_cnt;
        start_frame(3);
        wait_frame(d0, 1000);
        repeat (5) @(negedge clk);
        check("t3_frame_done_once", done_cnt - d0, 1);
        check("t3_desc_reads", desc_cnt - dr, 3);
        check("t3_mvp_reads", mvp_q.size() - ms, 32);
        ok = 1;
        for (int k = 0; k < 32; k++) if (mvp_q[ms + k] != 8'((k < 16) ? k : 32 + k - 16)) ok = 0;
        check("t3_mvp_addr_seq", ok, 1);
        check("t3_mvp_dv", mvp_dv_cnt - mdv, 2);
        check("t3_matrix_m2", mat_snap == exp_matrix(2), 1);
        check("t3_vtx_reads", vtx_q.size() - vs, 3);
        check("t3_vaddr2", vtx_q[vs + 2], 30);
        check("t3_vert_cnt", vert_q.size() - vq, 3);
        check("t3_last", {last_q[vq], last_q[vq + 1], last_q[vq + 2]}, 3'b011);
        check("t3_pipe_rst_pulses", prst_cnt - pr, 2);
        check("t3_tris", o_num_triangles, 2);

        // zero models
        ms = mvp_q.size(); vs = vtx_q.size(); dr = desc_cnt; d0 = done_cnt;
        @(posedge clk);
        #1 i_start = 1'b1;
        i_num_models = 5'd0;
        @(posedge clk);
        #1 i_start = 1'b0;
        @(negedge clk);
        check("t4_done_not_yet", o_frame_done, 0);
        check("t4_busy", o_busy, 1);
        @(negedge clk);
        check("t4_done_2cyc", o_frame_done, 1);
        check("t4_busy_falls", o_busy, 0);
        repeat (3) @(negedge clk);
        check("t4_no_reads", {32'(mvp_q.size() - ms), 32'(vtx_q.size() - vs), 32'(desc_cnt - dr)}, 0);
        check("t4_done_once", done_cnt - d0, 1);

        // vertex address wrap
        d_base[0] = 16383; d_count[0] = 2; d_tris[0] = 1;
        vs = vtx_q.size(); vq = vert_q.size(); d0 = done_cnt;
        start_frame(1);
        wait_frame(d0, 500);
        check("t5_frame_done", done_cnt - d0, 1);
        check("t5_vaddr0", vtx_q[vs], 16383);
        check("t5_vaddr1_wrap", vtx_q[vs + 1], 0);
        check("t5_vert1", vert_q[vq + 1], exp_vert(0));

        // async reset while waiting for the pipeline
        fin_enable = 1'b0;
        d_base[0] = 50; d_count[0] = 1; d_tris[0] = 1;
        d0 = done_cnt;
        start_frame(1);
        for (int c = 0; c < 200 && !(o_vertex_dv && o_vertex_last); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("t6_busy_in_wait", o_busy, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_pipe_rstn", o_pipe_rstn, 0);
        check("t6_rst_tris", o_num_triangles, 0);
        check("t6_rst_vertex", o_vertex, 0);
        check("t6_rst_matrix_zero", o_mvp_matrix == '0, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fin_enable = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_frame_done", done_cnt - d0, 0);
        d_base[0] = 60; d_count[0] = 2; d_tris[0] = 3;
        vq = vert_q.size(); d0 = done_cnt;
        start_frame(1);
        wait_frame(d0, 500);
        check("t6_rerun_done", done_cnt - d0, 1);
        check("t6_rerun_verts", vert_q.size() - vq, 2);
        check("t6_rerun_vert0", vert_q[vq], exp_vert(60));

        // start while busy is ignored
        d_base[0] = 70; d_count[0] = 1; d_tris[0] = 1;
        d_base[1] = 80; d_count[1] = 1; d_tris[1] = 1;
        for (int i = 2; i < 16; i++) begin d_base[i] = 90; d_count[i] = 1; d_tris[i] = 1; end
        vq = vert_q.size(); dr = desc_cnt; d0 = done_cnt;
        start_frame(2);
        repeat (4) @(posedge clk);
        #1 i_start = 1'b1;
        i_num_models = 5'd5;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_frame(d0, 1000);
        repeat (20) @(negedge clk);
        check("t7_done_once", done_cnt - d0, 1);
        check("t7_desc_reads", desc_cnt - dr, 2);
        check("t7_verts", vert_q.size() - vq, 2);
        check("t7_vert1", vert_q[vq + 1], exp_vert(80));
        check("t7_idle", o_busy, 0);

        check("protocol_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
